// File: rtl/spi_regs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_regs_pkg
// Purpose  : Shared frame geometry, register map and FSM encoding for the
//            SPI configuration target.
// Revision : 1.0 - initial release
// ============================================================================
package spi_regs_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;

   // Register map seen by the PWM block
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

   // Bit counter: 16 marks a complete frame, 17 is the sticky overflow marker
   localparam int               c_cnt_w        = 5;
   localparam logic [c_cnt_w-1:0] c_cnt_frame    = 5'd16;
   localparam logic [c_cnt_w-1:0] c_cnt_ovf      = 5'd17;
   // Count value just before the eighth header bit arrives
   localparam logic [c_cnt_w-1:0] c_cnt_rd_latch = 5'd7;
   localparam logic [c_cnt_w-1:0] c_cnt_rd_first = 5'd8;
   localparam logic [c_cnt_w-1:0] c_cnt_rd_last  = 5'd15;

   // Frame sequencer states
   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t SHIFT  = 2'd1;
   localparam state_t COMMIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/spi_peripheral_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_peripheral_if
// Purpose  : SPI pin bundle between an external host (master) and the
//            configuration target (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface spi_peripheral_if;
   logic sclk;
   logic copi;
   logic ncs;
   logic cipo;

   modport master (output sclk, output copi, output ncs, input cipo);
   modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface
`default_nettype wire

// File: rtl/sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Multi-flop synchronizer for one asynchronous pin, followed by a
//            history flop that yields single-cycle rise/fall pulses.
//            SYNC_STAGES must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  wire  clk,
   input  wire  rst_n,
   input  wire  i_din,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   // Resample the pin through the chain; the history flop holds the previous synced level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
         r_hist <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  =  o_level & ~r_hist;
   assign o_fall  = ~o_level &  r_hist;

endmodule
`default_nettype wire

// File: rtl/spi_peripheral.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_peripheral
// Purpose  : SPI mode-0 write target driving the five PWM configuration
//            registers. Pins are oversampled in the clk domain.
//            Optional macro SPI_READBACK_EN enables register readback on cipo.
// Revision : 1.0 - initial release
// ============================================================================
module spi_peripheral
   import spi_regs_pkg::*;
#(
   parameter int                SYNC_STAGES = 2,
   parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'h04
) (
   input  wire               clk,
   input  wire               rst_n,
   spi_peripheral_if.slave   spi,
   output logic [DATA_W-1:0] en_reg_out_7_0,
   output logic [DATA_W-1:0] en_reg_out_15_8,
   output logic [DATA_W-1:0] en_reg_pwm_7_0,
   output logic [DATA_W-1:0] en_reg_pwm_15_8,
   output logic [DATA_W-1:0] pwm_duty_cycle
);

   logic w_sclk_level, w_sclk_rise, w_sclk_fall;
   logic w_copi_level, w_copi_rise, w_copi_fall;
   logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [FRAME_W-1:0]   r_shreg;
   logic [DATA_W-1:0]    r_reg_out_lo, r_reg_out_hi;
   logic [DATA_W-1:0]    r_reg_pwm_lo, r_reg_pwm_hi;
   logic [DATA_W-1:0]    r_reg_duty;

   logic [ADDR_W-1:0]    w_addr;
   logic [DATA_W-1:0]    w_data;
   logic                 w_wr_en;
   logic                 w_unused;

   // Idle levels for mode 0: sclk low, copi low, ncs high
   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .i_din(spi.sclk),
      .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .i_din(spi.copi),
      .o_level(w_copi_level), .o_rise(w_copi_rise), .o_fall(w_copi_fall));

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .i_din(spi.ncs),
      .o_level(w_ncs_level), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall));

   // Frame sequencer: arm on nCS fall, shift on SCLK rise, qualify on nCS rise.
   // nCS rise is tested first so a coincident SCLK rise is never counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shreg <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ncs_fall) begin
                  r_state <= SHIFT;
                  r_cnt   <= '0;
                  r_shreg <= '0;
               end
            end
            SHIFT: begin
               if (w_ncs_rise) begin
                  r_state <= COMMIT;
               end else if (w_sclk_rise) begin
                  r_shreg <= {r_shreg[FRAME_W-2:0], w_copi_level};
                  if (r_cnt != c_cnt_ovf) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            COMMIT:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_addr  = r_shreg[FRAME_W-2 -: ADDR_W];
   assign w_data  = r_shreg[DATA_W-1:0];
   assign w_wr_en = (r_state == COMMIT) && (r_cnt == c_cnt_frame) &&
                    r_shreg[FRAME_W-1] && (w_addr <= MAX_ADDR);

   // Register file: at most one register updates, only on a fully qualified write frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg_out_lo <= '0;
         r_reg_out_hi <= '0;
         r_reg_pwm_lo <= '0;
         r_reg_pwm_hi <= '0;
         r_reg_duty   <= '0;
      end else if (w_wr_en) begin
         case (w_addr)
            ADDR_EN_OUT_7_0:  r_reg_out_lo <= w_data;
            ADDR_EN_OUT_15_8: r_reg_out_hi <= w_data;
            ADDR_EN_PWM_7_0:  r_reg_pwm_lo <= w_data;
            ADDR_EN_PWM_15_8: r_reg_pwm_hi <= w_data;
            ADDR_PWM_DUTY:    r_reg_duty   <= w_data;
            default: ;
         endcase
      end
   end

   assign en_reg_out_7_0  = r_reg_out_lo;
   assign en_reg_out_15_8 = r_reg_out_hi;
   assign en_reg_pwm_7_0  = r_reg_pwm_lo;
   assign en_reg_pwm_15_8 = r_reg_pwm_hi;
   assign pwm_duty_cycle  = r_reg_duty;

`ifdef SPI_READBACK_EN
   logic [ADDR_W-1:0] w_rd_addr;
   logic [DATA_W-1:0] w_rd_mux;
   logic              w_rd_latch;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_frame;
   logic              r_cipo;

   // The eighth header bit is still on copi when the latch fires, so the
   // address is assembled from the seven shifted bits plus the live bit.
   assign w_rd_addr  = {r_shreg[ADDR_W-2:0], w_copi_level};
   assign w_rd_latch = (r_state == SHIFT) && !w_ncs_rise && w_sclk_rise &&
                       (r_cnt == c_cnt_rd_latch) && !r_shreg[ADDR_W-1];

   // Readback source select; unmapped or out-of-range addresses read as zero
   always_comb begin
      w_rd_mux = '0;
      if (w_rd_addr <= MAX_ADDR) begin
         case (w_rd_addr)
            ADDR_EN_OUT_7_0:  w_rd_mux = r_reg_out_lo;
            ADDR_EN_OUT_15_8: w_rd_mux = r_reg_out_hi;
            ADDR_EN_PWM_7_0:  w_rd_mux = r_reg_pwm_lo;
            ADDR_EN_PWM_15_8: w_rd_mux = r_reg_pwm_hi;
            ADDR_PWM_DUTY:    w_rd_mux = r_reg_duty;
            default:          w_rd_mux = '0;
         endcase
      end
   end

   // Readback shifter: capture after the header, present MSB first on SCLK falls of bits 8..15
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data  <= '0;
         r_rd_frame <= 1'b0;
         r_cipo     <= 1'b0;
      end else if (r_state != SHIFT) begin
         r_rd_data  <= '0;
         r_rd_frame <= 1'b0;
         r_cipo     <= 1'b0;
      end else if (w_rd_latch) begin
         r_rd_data  <= w_rd_mux;
         r_rd_frame <= 1'b1;
      end else if (r_rd_frame && w_sclk_fall &&
                   (r_cnt >= c_cnt_rd_first) && (r_cnt <= c_cnt_rd_last)) begin
         r_cipo    <= r_rd_data[DATA_W-1];
         r_rd_data <= {r_rd_data[DATA_W-2:0], 1'b0};
      end
   end

   assign spi.cipo = r_cipo;
   assign w_unused = ^{w_sclk_level, w_copi_rise, w_copi_fall, w_ncs_level};
`else
   assign spi.cipo = 1'b0;
   assign w_unused = ^{w_sclk_level, w_sclk_fall, w_copi_rise, w_copi_fall, w_ncs_level};
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_peripheral
// Purpose  : Self-checking bench for spi_peripheral. A register model is
//            updated per frame and its snapshot queued; the snapshot is popped
//            and compared once the write latency has elapsed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_peripheral;
   import spi_regs_pkg::*;

   localparam int c_sync_stages = 2;
   localparam int c_latency     = c_sync_stages + 2;
   localparam int c_half        = 5;   // SCLK half period in clk cycles

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   spi_peripheral_if spi_bus();

   logic [7:0] out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty;

   int          n_checks = 0;
   int          n_errs   = 0;
   logic [7:0]  exp_regs [0:4];
   logic [39:0] sb_q [$];
   logic [15:0] cap;

   spi_peripheral #(.SYNC_STAGES(c_sync_stages), .MAX_ADDR(7'h04)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .spi             (spi_bus),
      .en_reg_out_7_0  (out_7_0),
      .en_reg_out_15_8 (out_15_8),
      .en_reg_pwm_7_0  (pwm_7_0),
      .en_reg_pwm_15_8 (pwm_15_8),
      .pwm_duty_cycle  (duty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame_begin();
      cap = '0;
      spi_bus.ncs = 1'b0;
      wait_clk(3);
   endtask

   // Send n bits MSB first; cipo is captured just before each SCLK rise
   task automatic send_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         spi_bus.copi = bits[i];
         wait_clk(c_half);
         cap = {cap[14:0], spi_bus.cipo};
         spi_bus.sclk = 1'b1;
         wait_clk(c_half);
         spi_bus.sclk = 1'b0;
      end
   endtask

   task automatic frame_end();
      wait_clk(3);
      spi_bus.ncs  = 1'b1;
      spi_bus.copi = 1'b0;
   endtask

   function automatic logic [39:0] model_snap();
      return {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
   endfunction

   function automatic logic [7:0] model_read(input logic [6:0] a);
      return (a <= 7'h04) ? exp_regs[a[2:0]] : 8'h00;
   endfunction

   task automatic model_frame(input logic [31:0] bits, input int n);
      logic [6:0] a;
      a = bits[14:8];
      if (n == 16 && bits[15] && a <= 7'h04) exp_regs[a[2:0]] = bits[7:0];
      sb_q.push_back(model_snap());
   endtask

   task automatic compare_regs(input string tag, input logic [39:0] e);
      check({tag, ".out_7_0"},  out_7_0,  e[7:0]);
      check({tag, ".out_15_8"}, out_15_8, e[15:8]);
      check({tag, ".pwm_7_0"},  pwm_7_0,  e[23:16]);
      check({tag, ".pwm_15_8"}, pwm_15_8, e[31:24]);
      check({tag, ".duty"},     duty,     e[39:32]);
   endtask

   task automatic sb_compare(input string tag);
      logic [39:0] e;
      wait_clk(c_latency);
      check({tag, ".sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         compare_regs(tag, e);
      end
   endtask

   // Full frame with scoreboard check; read frames also check the cipo stream
   task automatic do_frame(input string tag, input logic [31:0] bits, input int n);
      logic [15:0] exp_cap;
      exp_cap = '0;
`ifdef SPI_READBACK_EN
      if (n == 16 && !bits[15]) exp_cap = {8'h00, model_read(bits[14:8])};
`endif
      frame_begin();
      send_bits(bits, n);
      frame_end();
      model_frame(bits, n);
      if (n == 16 && !bits[15]) check({tag, ".cipo"}, cap, exp_cap);
      sb_compare(tag);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      spi_bus.sclk = 1'b0;
      spi_bus.copi = 1'b0;
      spi_bus.ncs  = 1'b1;
      for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;

      wait_clk(3);
      compare_regs("reset", 40'h0);
      check("reset.cipo", spi_bus.cipo, 0);
      rst_n = 1'b1;
      wait_clk(4);

      do_frame("wr_out_lo", 32'h80F0, 16);
      do_frame("wr_duty",   32'h8480, 16);
      do_frame("wr_pwm_hi", 32'h83A5, 16);
      do_frame("bad_addr",  32'hB0FF, 16);
      do_frame("addr_5",    32'h85FF, 16);
      do_frame("read_00",   32'h00FF, 16);
      do_frame("short15",   32'h80F0 >> 1, 15);
      do_frame("long17",    {15'h0, 1'b1, 16'h8299}, 17);

      // Sixteenth SCLK rise coincides with nCS rise: must not complete the frame
      frame_begin();
      send_bits(32'h8111 >> 1, 15);
      spi_bus.copi = 1'b1;
      wait_clk(c_half);
      spi_bus.sclk = 1'b1;
      spi_bus.ncs  = 1'b1;
      wait_clk(c_half);
      spi_bus.sclk = 1'b0;
      model_frame(32'h8111, 15);
      sb_compare("sclk_ncs_tie");

      // SCLK activity with nCS deasserted
      for (int i = 0; i < 16; i++) begin
         spi_bus.copi = 1'b1;
         wait_clk(c_half);
         spi_bus.sclk = 1'b1;
         wait_clk(c_half);
         spi_bus.sclk = 1'b0;
      end
      spi_bus.copi = 1'b0;
      model_frame(32'h0, 0);
      sb_compare("sclk_ncs_hi");

      do_frame("wr_out_hi", 32'h8155, 16);

      // Reset in the middle of a frame discards it
      frame_begin();
      send_bits(32'h8277 >> 7, 9);
      rst_n = 1'b0;
      #1;
      compare_regs("mid_reset", 40'h0);
      check("mid_reset.cipo", spi_bus.cipo, 0);
      for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
      wait_clk(3);
      spi_bus.ncs  = 1'b1;
      spi_bus.copi = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(4);
      do_frame("wr_pwm_lo", 32'h8233, 16);

      do_frame("wr_out_66", 32'h8066, 16);
      do_frame("read_66",   32'h0000, 16);
      do_frame("read_duty", 32'h0400, 16);
      check("idle.cipo", spi_bus.cipo, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
      $finish;
   end

endmodule
`default_nettype wire
